// File: rtl/mem_axi_bridge_if.sv
// mem_axi_bridge_if: bundles the mem-stage request/response bus and the AXI4-Lite master bus.
// master modport is the bridge's view; slave modport is the mem stage plus interconnect side.
// Ports carried: request_enable/mode/addr/wdata/wstrb in; response_enable/data/bus_error/busy out;
//   AXI4-Lite AR, R, AW, W, B channels.
interface mem_axi_bridge_if;
  // mem stage side
  logic        request_enable;
  logic        mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        response_enable;
  logic [31:0] data;
  logic        bus_error;
  logic        busy;
  // AXI4-Lite read address / read data
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  // AXI4-Lite write address / write data / write response
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  modport master (
    input  request_enable, mode, addr, wdata, wstrb,
    output response_enable, data, bus_error, busy,
    output m_axi_araddr, m_axi_arvalid, input m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready,
    output m_axi_awaddr, m_axi_awvalid, input m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid, output m_axi_bready
  );

  modport slave (
    output request_enable, mode, addr, wdata, wstrb,
    input  response_enable, data, bus_error, busy,
    input  m_axi_araddr, m_axi_arvalid, output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready,
    input  m_axi_awaddr, m_axi_awvalid, output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid, input m_axi_bready
  );
endinterface

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: turns the mem stage's single-outstanding request bus into AXI4-Lite master transactions.
// Latency: request N -> response_enable N+3 with a zero-wait slave; one transaction in flight, no queueing.
// Backpressure: AXI valids held until handshake; mem stage stalls on response_enable; requests while busy are dropped.
// Ports: clk, rstn (async active-low), bus (mem_axi_bridge_if.master).
// Option: BRIDGE_TIMEOUT_EN aborts any handshake wait after TIMEOUT_CYCLES cycles with bus_error.
module mem_axi_bridge
`ifdef BRIDGE_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 1024)
`endif
(
  input  logic             clk,
  input  logic             rstn,
  mem_axi_bridge_if.master bus
);

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [3:0]  r_wstrb, w_wstrb_nxt;
  logic        r_arvalid, w_arvalid_nxt;
  logic        r_rready, w_rready_nxt;
  logic        r_awvalid, w_awvalid_nxt;
  logic        r_wvalid, w_wvalid_nxt;
  logic        r_bready, w_bready_nxt;
  logic        r_resp_en, w_resp_en_nxt;
  logic        r_bus_err, w_bus_err_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        w_aw_done, w_w_done;

`ifdef BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt, w_cnt_nxt;
`endif

  // A write channel counts as done once its valid has dropped or it handshakes this cycle.
  assign w_aw_done = ~r_awvalid | bus.m_axi_awready;
  assign w_w_done  = ~r_wvalid  | bus.m_axi_wready;

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_bready_nxt  = r_bready;
    w_data_nxt    = r_data;
    w_resp_en_nxt = 1'b0;
    w_bus_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.request_enable) begin
          w_addr_nxt  = bus.addr;
          w_wdata_nxt = bus.wdata;
          w_wstrb_nxt = bus.wstrb;
          case (bus.mode)
            MEMREQ_READ: begin
              w_arvalid_nxt = 1'b1;
              w_state_nxt   = S_RD_ADDR;
            end
            MEMREQ_WRITE: begin
              w_awvalid_nxt = 1'b1;
              w_wvalid_nxt  = 1'b1;
              w_state_nxt   = S_WR_REQ;
            end
          endcase
        end
      end
      S_RD_ADDR: begin
        if (bus.m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bus.m_axi_rvalid && r_rready) begin
          w_rready_nxt  = 1'b0;
          w_data_nxt    = bus.m_axi_rdata;
          w_resp_en_nxt = 1'b1;
          w_bus_err_nxt = (bus.m_axi_rresp != 2'b00);
          w_state_nxt   = S_IDLE;
        end
      end
      S_WR_REQ: begin
        if (w_aw_done && w_w_done) begin
          w_awvalid_nxt = 1'b0;
          w_wvalid_nxt  = 1'b0;
          w_bready_nxt  = 1'b1;
          w_state_nxt   = S_WR_RESP;
        end else begin
          if (bus.m_axi_awready) w_awvalid_nxt = 1'b0;
          if (bus.m_axi_wready)  w_wvalid_nxt  = 1'b0;
        end
      end
      S_WR_RESP: begin
        if (bus.m_axi_bvalid) begin
          w_bready_nxt  = 1'b0;
          w_data_nxt    = 32'h0;
          w_resp_en_nxt = 1'b1;
          w_bus_err_nxt = (bus.m_axi_bresp != 2'b00);
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef BRIDGE_TIMEOUT_EN
    // Abort only when the state would otherwise stay put, i.e. the awaited handshake did not happen.
    if (r_state != S_IDLE && w_state_nxt == r_state && r_cnt == TO_LAST) begin
      w_arvalid_nxt = 1'b0;
      w_rready_nxt  = 1'b0;
      w_awvalid_nxt = 1'b0;
      w_wvalid_nxt  = 1'b0;
      w_bready_nxt  = 1'b0;
      w_data_nxt    = 32'h0;
      w_resp_en_nxt = 1'b1;
      w_bus_err_nxt = 1'b1;
      w_state_nxt   = S_IDLE;
    end
    // Counter restarts on every state change so each handshake gets its own budget.
    if (r_state == S_IDLE || w_state_nxt != r_state) w_cnt_nxt = 16'd0;
    else                                             w_cnt_nxt = r_cnt + 16'd1;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_resp_en <= 1'b0;
      r_bus_err <= 1'b0;
      r_data    <= 32'h0;
`ifdef BRIDGE_TIMEOUT_EN
      r_cnt     <= 16'd0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_resp_en <= w_resp_en_nxt;
      r_bus_err <= w_bus_err_nxt;
      r_data    <= w_data_nxt;
`ifdef BRIDGE_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
`endif
    end
  end

  assign bus.response_enable = r_resp_en;
  assign bus.bus_error       = r_bus_err;
  assign bus.data            = r_data;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.m_axi_araddr    = r_addr;
  assign bus.m_axi_arvalid   = r_arvalid;
  assign bus.m_axi_rready    = r_rready;
  assign bus.m_axi_awaddr    = r_addr;
  assign bus.m_axi_awvalid   = r_awvalid;
  assign bus.m_axi_wdata     = r_wdata;
  assign bus.m_axi_wstrb     = r_wstrb;
  assign bus.m_axi_wvalid    = r_wvalid;
  assign bus.m_axi_bready    = r_bready;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// tb_mem_axi_bridge: vector table plus hand sequences against mem_axi_bridge with a scripted AXI slave.
// Each vector gives per-channel ready/valid cycles relative to the request cycle and the expected response.
// Expected responses go to a scoreboard queue at request time and are popped when response_enable fires.
module tb_mem_axi_bridge;

  localparam logic MODE_RD = 1'b0;
  localparam logic MODE_WR = 1'b1;
  localparam int   NV      = 8;

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ar_at, r_at, aw_at, w_at, b_at;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_axi_bridge_if bus();

`ifdef BRIDGE_TIMEOUT_EN
  mem_axi_bridge #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rstn(rstn), .bus(bus.master));
`else
  mem_axi_bridge dut (.clk(clk), .rstn(rstn), .bus(bus.master));
`endif

  vec_t vecs[NV];
  vec_t cfg;
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t0 = 0;
  bit   sl_active = 1'b0;
  int   r_hs_cyc = -1;
  int   b_hs_cyc = -1;

  function automatic vec_t mk(input logic m, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input int ar, input int r, input int aw,
                              input int w, input int b, input logic [31:0] rd, input logic [1:0] rs,
                              input logic [31:0] ed, input logic ee, input int el);
    vec_t v;
    v.mode = m; v.addr = a; v.wdata = wd; v.wstrb = ws;
    v.ar_at = ar; v.r_at = r; v.aw_at = aw; v.w_at = w; v.b_at = b;
    v.rdata = rd; v.resp = rs; v.exp_data = ed; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scripted slave: drives ready/valid for the current cycle shortly after each rising edge.
  initial begin
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = 32'h0; bus.m_axi_rresp = 2'b00;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      bus.m_axi_rdata   = cfg.rdata;
      bus.m_axi_rresp   = cfg.resp;
      bus.m_axi_bresp   = cfg.resp;
      bus.m_axi_arready = sl_active && cfg.mode == MODE_RD && cyc >= t0 + cfg.ar_at;
      bus.m_axi_rvalid  = sl_active && cfg.mode == MODE_RD && r_hs_cyc < t0 && cyc >= t0 + cfg.r_at;
      bus.m_axi_awready = sl_active && cfg.mode == MODE_WR && cyc >= t0 + cfg.aw_at;
      bus.m_axi_wready  = sl_active && cfg.mode == MODE_WR && cyc >= t0 + cfg.w_at;
      bus.m_axi_bvalid  = sl_active && cfg.mode == MODE_WR && b_hs_cyc < t0 && cyc >= t0 + cfg.b_at;
    end
  end

  // Monitor: protocol stability, handshake payloads, and scoreboard comparison of responses.
  logic        p_rstn = 1'b0, p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0;
  logic        p_wv = 1'b0, p_wr = 1'b0, p_resp = 1'b0;
  logic [31:0] p_araddr = 32'h0, p_awaddr = 32'h0, p_wdata = 32'h0, p_data = 32'h0;
  logic [3:0]  p_wstrb = 4'h0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && p_rstn) begin
        if (p_arv && !p_arr && !bus.response_enable) begin
          check("arvalid_hold", bus.m_axi_arvalid, 1);
          check("araddr_stable", bus.m_axi_araddr, p_araddr);
        end
        if (p_awv && !p_awr && !bus.response_enable) begin
          check("awvalid_hold", bus.m_axi_awvalid, 1);
          check("awaddr_stable", bus.m_axi_awaddr, p_awaddr);
        end
        if (p_wv && !p_wr && !bus.response_enable) begin
          check("wvalid_hold", bus.m_axi_wvalid, 1);
          check("wdata_stable", bus.m_axi_wdata, p_wdata);
          check("wstrb_stable", {28'h0, bus.m_axi_wstrb}, {28'h0, p_wstrb});
        end
        if (p_resp && !bus.response_enable) check("data_held", bus.data, p_data);
      end
      if (rstn) begin
        if (bus.m_axi_arvalid && bus.m_axi_arready) check("araddr", bus.m_axi_araddr, cfg.addr);
        if (bus.m_axi_awvalid && bus.m_axi_awready) check("awaddr", bus.m_axi_awaddr, cfg.addr);
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          check("wdata", bus.m_axi_wdata, cfg.wdata);
          check("wstrb", {28'h0, bus.m_axi_wstrb}, {28'h0, cfg.wstrb});
        end
        if (bus.m_axi_rvalid && bus.m_axi_rready) r_hs_cyc = cyc;
        if (bus.m_axi_bvalid && bus.m_axi_bready) b_hs_cyc = cyc;
        if (bus.bus_error) check("err_only_with_resp", bus.response_enable, 1);
        if (bus.response_enable) begin
          check("busy_at_resp", bus.busy, 0);
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: response_enable=1 at cycle %0d, required no response", cyc);
          end else begin
            e = sb.pop_front();
            check("resp_data", bus.data, e.data);
            check("resp_err", bus.bus_error, e.err);
            check("resp_latency", cyc - e.t0, e.lat);
          end
        end
      end
      p_rstn = rstn; p_resp = bus.response_enable; p_data = bus.data;
      p_arv = bus.m_axi_arvalid; p_arr = bus.m_axi_arready; p_araddr = bus.m_axi_araddr;
      p_awv = bus.m_axi_awvalid; p_awr = bus.m_axi_awready; p_awaddr = bus.m_axi_awaddr;
      p_wv = bus.m_axi_wvalid; p_wr = bus.m_axi_wready; p_wdata = bus.m_axi_wdata; p_wstrb = bus.m_axi_wstrb;
    end
  end

  // Called at a falling edge; drives a one-cycle request and returns at the next falling edge.
  task automatic issue(input vec_t v, input bit push);
    exp_t e;
    cfg = v;
    t0 = cyc;
    sl_active = 1'b1;
    bus.request_enable = 1'b1;
    bus.mode = v.mode; bus.addr = v.addr; bus.wdata = v.wdata; bus.wstrb = v.wstrb;
    if (push) begin
      e.data = v.exp_data; e.err = v.exp_err; e.lat = v.exp_lat; e.t0 = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.request_enable = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL resp_timeout: %0d responses pending after %0d cycles, required 0", sb.size(), budget);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int   n;
    //          mode     addr          wdata         wstrb    ar r  aw w  b  rdata         rs     exp_data      err lat
    vecs[0] = mk(MODE_RD, 32'h0000_1000, 32'h0,        4'h0,    1, 2, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 0, 3);
    vecs[1] = mk(MODE_WR, 32'h0000_0100, 32'h1234_5678, 4'b0100, 0, 0, 1, 4, 6, 32'h0,        2'b00, 32'h0,        0, 7);
    vecs[2] = mk(MODE_RD, 32'h0000_2008, 32'h0,        4'h0,    1, 2, 0, 0, 0, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D, 1, 3);
    vecs[3] = mk(MODE_WR, 32'h0000_0FFC, 32'hA5A5_5A5A, 4'b1111, 0, 0, 1, 1, 2, 32'h0,        2'b00, 32'h0,        0, 3);
    vecs[4] = mk(MODE_WR, 32'h2000_0004, 32'h0000_0000, 4'b0001, 0, 0, 5, 1, 6, 32'h0,        2'b11, 32'h0,        1, 7);
    vecs[5] = mk(MODE_RD, 32'hFFFF_FFFC, 32'h0,        4'h0,    4, 5, 0, 0, 0, 32'h0000_00A5, 2'b00, 32'h0000_00A5, 0, 6);
    vecs[6] = mk(MODE_RD, 32'h0000_0040, 32'h0,        4'h0,    2, 9, 0, 0, 0, 32'h1234_5678, 2'b01, 32'h1234_5678, 1, 10);
    vecs[7] = mk(MODE_WR, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1010, 0, 0, 3, 3, 4, 32'h0,        2'b10, 32'h0,        1, 5);
    cfg = vecs[0];
    bus.request_enable = 1'b0; bus.mode = MODE_RD; bus.addr = 32'h0; bus.wdata = 32'h0; bus.wstrb = 4'h0;

    repeat (3) @(negedge clk);
    check("rst_arvalid", bus.m_axi_arvalid, 0);
    check("rst_rready", bus.m_axi_rready, 0);
    check("rst_awvalid", bus.m_axi_awvalid, 0);
    check("rst_wvalid", bus.m_axi_wvalid, 0);
    check("rst_bready", bus.m_axi_bready, 0);
    check("rst_resp_en", bus.response_enable, 0);
    check("rst_bus_error", bus.bus_error, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_data", bus.data, 0);
    check("rst_araddr", bus.m_axi_araddr, 0);
    check("rst_wdata", bus.m_axi_wdata, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i], 1'b1);
      check("busy_after_req", bus.busy, 1);
      wait_done(40);
    end

    // Back-to-back: a new request in the same cycle as the previous response.
    issue(vecs[0], 1'b1);
    n = 0;
    while (!bus.response_enable && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_resp", bus.response_enable, 1);
    issue(vecs[3], 1'b1);
    check("b2b_busy", bus.busy, 1);
    wait_done(40);

    // Reset while waiting for read data: abandoned with no response.
    v = vecs[5];
    v.ar_at = 1; v.r_at = 1000;
    issue(v, 1'b0);
    n = 0;
    while (!bus.m_axi_rready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_in_rd_data", bus.m_axi_rready, 1);
    rstn = 1'b0;
    sl_active = 1'b0;
    #1;
    check("rst_mid_arvalid", bus.m_axi_arvalid, 0);
    check("rst_mid_rready", bus.m_axi_rready, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_data", bus.data, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_idle", bus.busy, 0);
    issue(vecs[0], 1'b1);
    wait_done(40);

`ifdef BRIDGE_TIMEOUT_EN
    // arready never comes: abort 16 cycles after entering RD_ADDR.
    v = vecs[0];
    v.ar_at = 100000; v.exp_data = 32'h0; v.exp_err = 1'b1; v.exp_lat = 17;
    issue(v, 1'b1);
    wait_done(40);
    check("timeout_busy_after", bus.busy, 0);
    check("timeout_arvalid_after", bus.m_axi_arvalid, 0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
